// File: rtl/lcd_defs.sv
// Shared constants for the HD44780 character writer: command bytes, ASCII codes,
// FSM state encodings and the byte-selection helpers used by the sequencer.
package lcd_defs;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;

    localparam logic [7:0] ASCII_COLON  = 8'h3A;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;

    typedef enum logic [1:0] {
        T_PWRUP,
        T_INIT,
        T_IDLE,
        T_FRAME
    } top_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_EHI,
        W_WAIT
    } wr_state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = CMD_FUNC_SET;
            2'd1:    init_cmd = CMD_DISP_ON;
            2'd2:    init_cmd = CMD_ENTRY;
            default: init_cmd = CMD_CLEAR;
        endcase
    endfunction

    // Slot 0 is the line-1 address command; slots 1..7 are the "HH:MM A" characters.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [7:0] h1, input logic [7:0] h0,
                                              input logic [7:0] m1, input logic [7:0] m0,
                                              input logic alarm);
        case (idx)
            3'd1:    frame_byte = h1;
            3'd2:    frame_byte = h0;
            3'd3:    frame_byte = ASCII_COLON;
            3'd4:    frame_byte = m1;
            3'd5:    frame_byte = m0;
            3'd6:    frame_byte = ASCII_SPACE;
            3'd7:    frame_byte = alarm ? ASCII_STAR : ASCII_SPACE;
            default: frame_byte = CMD_LINE1;
        endcase
    endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One HD44780 bus write: setup with E low, E high pulse, then the post-write wait.
// Handshake: start is sampled only in W_IDLE; done pulses for one cycle after W_WAIT ends.
module lcd_write_cycle
    import lcd_defs::*;
#(
    parameter int SETUP_CYCLES      = 2,
    parameter int E_HIGH_CYCLES     = 12,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       done,
    output wr_state_t  state
);

    localparam int MAX_A    = (SETUP_CYCLES > E_HIGH_CYCLES) ? SETUP_CYCLES : E_HIGH_CYCLES;
    localparam int MAX_B    = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES
                                                                    : CLEAR_WAIT_CYCLES;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EHI_LAST   = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] wait_last;
    logic             long_q;

    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign wait_last = long_q ? CLEAR_LAST : CMD_LAST;

    // rs/data are latched on start and left untouched until the next start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= W_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                W_IDLE: begin
                    if (start) begin
                        lcd_rs   <= rs;
                        lcd_data <= data;
                        long_q   <= long_wait;
                        cnt      <= '0;
                        state    <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        lcd_e <= 1'b1;
                        state <= W_EHI;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                W_EHI: begin
                    if (cnt == EHI_LAST) begin
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                        state <= W_WAIT;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                W_WAIT: begin
                    if (cnt == wait_last) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= W_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_writer.sv
// Drives an 8-bit write-only HD44780 LCD: power-up wait, init commands, then rewrites
// line 1 as "HH:MM A" whenever any displayed input differs from the last frame's snapshot.
module lcd_char_writer
    import lcd_defs::*;
#(
    parameter int POWERUP_CYCLES    = 750000,
    parameter int SETUP_CYCLES      = 2,
    parameter int E_HIGH_CYCLES     = 12,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ms_hour,
    input  logic [7:0] ls_hour,
    input  logic [7:0] ms_minute,
    input  logic [7:0] ls_minute,
    input  logic       alarm_sound,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       init_done,
    output logic       busy
);

    localparam int PW_W = $clog2(POWERUP_CYCLES + 1);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(POWERUP_CYCLES - 1);

    top_state_t  state;
    logic [PW_W-1:0] pw_cnt;
    logic [2:0]  idx;
    logic        wr_start;
    logic        wr_rs;
    logic [7:0]  wr_data;
    logic        wr_long;
    logic        wr_done;
    wr_state_t   wr_state;

    logic [7:0]  snap_h1, snap_h0, snap_m1, snap_m0;
    logic        snap_al;
    logic        first_frame;
    logic        changed;
    logic        trigger;

    assign lcd_rw  = 1'b0;
    assign wr_long = !wr_rs && (wr_data == CMD_CLEAR);
    assign changed = {ms_hour, ls_hour, ms_minute, ls_minute, alarm_sound}
                  != {snap_h1, snap_h0, snap_m1, snap_m0, snap_al};
    assign trigger = first_frame || changed;

    lcd_write_cycle #(
        .SETUP_CYCLES      (SETUP_CYCLES),
        .E_HIGH_CYCLES     (E_HIGH_CYCLES),
        .CMD_WAIT_CYCLES   (CMD_WAIT_CYCLES),
        .CLEAR_WAIT_CYCLES (CLEAR_WAIT_CYCLES)
    ) u_write (
        .clock     (clock),
        .reset     (reset),
        .start     (wr_start),
        .rs        (wr_rs),
        .data      (wr_data),
        .long_wait (wr_long),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data),
        .done      (wr_done),
        .state     (wr_state)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= T_PWRUP;
            pw_cnt      <= '0;
            idx         <= 3'd0;
            wr_start    <= 1'b0;
            wr_rs       <= 1'b0;
            wr_data     <= 8'h00;
            snap_h1     <= 8'h00;
            snap_h0     <= 8'h00;
            snap_m1     <= 8'h00;
            snap_m0     <= 8'h00;
            snap_al     <= 1'b0;
            first_frame <= 1'b0;
            init_done   <= 1'b0;
            busy        <= 1'b1;
        end else begin
            wr_start <= 1'b0;
            case (state)
                T_PWRUP: begin
                    busy <= 1'b1;
                    if (pw_cnt == PW_LAST) begin
                        state    <= T_INIT;
                        idx      <= 3'd0;
                        wr_start <= 1'b1;
                        wr_rs    <= 1'b0;
                        wr_data  <= init_cmd(2'd0);
                    end else if (pw_cnt != '1) begin
                        pw_cnt <= pw_cnt + PW_W'(1);
                    end
                end
                T_INIT: begin
                    busy <= 1'b1;
                    if (wr_done) begin
                        if (idx == 3'd3) begin
                            state       <= T_IDLE;
                            init_done   <= 1'b1;
                            first_frame <= 1'b1;
                        end else begin
                            idx      <= idx + 3'd1;
                            wr_start <= 1'b1;
                            wr_rs    <= 1'b0;
                            wr_data  <= init_cmd(idx[1:0] + 2'd1);
                        end
                    end
                end
                T_IDLE: begin
                    // Inputs are captured only here, so mid-frame edits show up as a
                    // mismatch on return and collapse into a single follow-up frame.
                    if (trigger && wr_state == W_IDLE) begin
                        snap_h1     <= ms_hour;
                        snap_h0     <= ls_hour;
                        snap_m1     <= ms_minute;
                        snap_m0     <= ls_minute;
                        snap_al     <= alarm_sound;
                        first_frame <= 1'b0;
                        state       <= T_FRAME;
                        idx         <= 3'd0;
                        wr_start    <= 1'b1;
                        wr_rs       <= 1'b0;
                        wr_data     <= CMD_LINE1;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                T_FRAME: begin
                    busy <= 1'b1;
                    if (wr_done) begin
                        if (idx == 3'd7) begin
                            state <= T_IDLE;
                        end else begin
                            idx      <= idx + 3'd1;
                            wr_start <= 1'b1;
                            wr_rs    <= 1'b1;
                            wr_data  <= frame_byte(idx + 3'd1, snap_h1, snap_h0,
                                                   snap_m1, snap_m0, snap_al);
                        end
                    end
                end
                default: state <= T_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer: a bus monitor captures every E pulse with its
// timing, and a scoreboard compares captured {rs,data} against an expected queue.
module tb_lcd_char_writer;

    logic       clock;
    logic       reset;
    logic [7:0] ms_hour, ls_hour, ms_minute, ls_minute;
    logic       alarm_sound;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_e, init_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] cap_q[$];
    int         width_q[$];
    int         setup_q[$];
    int         gap_q[$];
    int         rise_cnt = 0;

    lcd_char_writer #(
        .POWERUP_CYCLES    (20),
        .SETUP_CYCLES      (2),
        .E_HIGH_CYCLES     (4),
        .CMD_WAIT_CYCLES   (10),
        .CLEAR_WAIT_CYCLES (30)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .ms_hour     (ms_hour),
        .ls_hour     (ls_hour),
        .ms_minute   (ms_minute),
        .ls_minute   (ls_minute),
        .alarm_sound (alarm_sound),
        .lcd_data    (lcd_data),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .init_done   (init_done),
        .busy        (busy)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // bus monitor: one record per E pulse (bus value, high width, prior stability, prior low time)
    initial begin
        logic       prev_e;
        logic [8:0] prev_bus, bus, r_bus;
        int         stab, low_cnt, hi_cnt, r_setup, r_gap;
        prev_e = 1'b0; prev_bus = '0; stab = 0; low_cnt = 0; hi_cnt = 0;
        r_bus = '0; r_setup = 0; r_gap = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_e = 1'b0; prev_bus = '0; stab = 0; low_cnt = 0; hi_cnt = 0;
            end else begin
                bus = {lcd_rs, lcd_data};
                if (bus == prev_bus) stab++;
                else stab = 0;
                prev_bus = bus;
                if (lcd_e && !prev_e) begin
                    r_bus = bus; r_setup = stab; r_gap = low_cnt; hi_cnt = 1;
                    rise_cnt++;
                end else if (lcd_e) begin
                    hi_cnt++;
                end else if (prev_e) begin
                    cap_q.push_back(r_bus);
                    width_q.push_back(hi_cnt);
                    setup_q.push_back(r_setup);
                    gap_q.push_back(r_gap);
                    low_cnt = 1;
                end else begin
                    low_cnt++;
                end
                prev_e = lcd_e;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_caps(input int n, input int budget);
        int c = 0;
        while (cap_q.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        check_eq("wait_caps", 32'(cap_q.size() >= n), 1);
    endtask

    task automatic wait_busy_low(input int budget);
        int c = 0;
        while (busy !== 1'b0 && c < budget) begin
            @(negedge clock);
            c++;
        end
        check_eq("busy_low", 32'(busy), 0);
    endtask

    task automatic score(input int n);
        logic [8:0] got, exp;
        for (int i = 0; i < n; i++) begin
            if (cap_q.size() == 0 || exp_q.size() == 0) begin
                check_eq("score_empty", 0, 1);
            end else begin
                got = cap_q.pop_front();
                exp = exp_q.pop_front();
                check_eq("bus_byte", 32'(got), 32'(exp));
                check_eq("e_width", 32'(width_q.pop_front()), 4);
                check_eq("setup", 32'(setup_q.pop_front() >= 2), 1);
                void'(gap_q.pop_front());
            end
        end
    endtask

    task automatic push_frame(input logic [7:0] h1, input logic [7:0] h0,
                              input logic [7:0] m1, input logic [7:0] m0, input logic al);
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b1, h1});
        exp_q.push_back({1'b1, h0});
        exp_q.push_back({1'b1, 8'h3A});
        exp_q.push_back({1'b1, m1});
        exp_q.push_back({1'b1, m0});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b1, al ? 8'h2A : 8'h20});
    endtask

    task automatic check_reset_values();
        check_eq("rst_e", 32'(lcd_e), 0);
        check_eq("rst_rs", 32'(lcd_rs), 0);
        check_eq("rst_rw", 32'(lcd_rw), 0);
        check_eq("rst_data", 32'(lcd_data), 0);
        check_eq("rst_init_done", 32'(init_done), 0);
        check_eq("rst_busy", 32'(busy), 1);
    endtask

    task automatic check_init();
        int c = 0;
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
        wait_caps(4, 500);
        if (gap_q.size() > 0) check_eq("pwrup_gap", 32'(gap_q[0] >= 20), 1);
        else check_eq("pwrup_gap_missing", 0, 1);
        score(4);
        while (init_done !== 1'b1 && c < 200) begin
            @(negedge clock);
            c++;
        end
        check_eq("init_done", 32'(init_done), 1);
    endtask

    initial begin
        int base;
        int c;
        reset = 1'b1;
        ms_hour = 8'h31; ls_hour = 8'h32; ms_minute = 8'h33; ls_minute = 8'h34;
        alarm_sound = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values();
        reset = 1'b0;

        // 1: power-up wait and init commands
        check_init();

        // 2: first frame 12:34, no alarm
        push_frame(8'h31, 8'h32, 8'h33, 8'h34, 1'b0);
        wait_caps(8, 1000);
        if (gap_q.size() > 0) check_eq("clear_wait", 32'(gap_q[0] >= 30), 1);
        else check_eq("clear_wait_missing", 0, 1);
        score(8);
        wait_busy_low(200);

        // 3: stable inputs produce no traffic
        base = rise_cnt;
        repeat (1000) @(negedge clock);
        check_eq("idle_pulses", 32'(rise_cnt - base), 0);
        check_eq("idle_busy", 32'(busy), 0);

        // 4: change ls_minute while the third data byte is on the bus
        ms_hour = 8'h30;
        base = rise_cnt;
        c = 0;
        while (rise_cnt < base + 4 && c < 1000) begin
            @(negedge clock);
            c++;
        end
        check_eq("third_byte_reached", 32'(rise_cnt >= base + 4), 1);
        ls_minute = 8'h35;
        push_frame(8'h30, 8'h32, 8'h33, 8'h34, 1'b0);
        push_frame(8'h30, 8'h32, 8'h33, 8'h35, 1'b0);
        wait_caps(16, 2000);
        score(16);
        wait_busy_low(200);

        // 5: alarm indicator on and off
        alarm_sound = 1'b1;
        push_frame(8'h30, 8'h32, 8'h33, 8'h35, 1'b1);
        wait_caps(8, 1000);
        score(8);
        wait_busy_low(200);
        alarm_sound = 1'b0;
        push_frame(8'h30, 8'h32, 8'h33, 8'h35, 1'b0);
        wait_caps(8, 1000);
        score(8);
        wait_busy_low(200);

        // 6: async reset while E is high, then full re-init
        ms_hour = 8'h32;
        c = 0;
        while (lcd_e !== 1'b1 && c < 500) begin
            @(negedge clock);
            c++;
        end
        check_eq("e_high_before_reset", 32'(lcd_e), 1);
        #2 reset = 1'b1;
        #1 check_reset_values();
        repeat (3) @(negedge clock);
        cap_q.delete(); width_q.delete(); setup_q.delete(); gap_q.delete(); exp_q.delete();
        reset = 1'b0;
        check_init();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
